boot_loader_ctrl: RTL and testbench

- Boot sequencer and memory-port owner that sits between the cpu core, the UART receiver and the shared program/data RAM.
- While loading, it holds the cpu in reset, assembles a byte stream into 32-bit words and writes them into RAM.
- When the load completes it hands the RAM port back to the cpu and releases cpu reset.
- A boot request at any time re-enters loading.

---
 rtl/boot_loader_ctrl.sv | 156 +++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader_ctrl.sv
// rtl/boot_loader_ctrl.sv - boot sequencer: loads a UART frame into RAM, then hands the RAM port to the cpu
module boot_loader_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        boot_req,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic [31:0] cpu_mem_addr,
   input  logic [31:0] cpu_mem_wdata,
   input  logic        cpu_mem_rstrb,
   input  logic [3:0]  cpu_mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_rstrb,
   output logic [3:0]  mem_wstrb,
   output logic        cpu_rst_n,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_RELEASE,
      S_RUN,
      S_ERR
   } state_t;

   localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

   state_t      state_q, state_d;
   logic [15:0] n_q, n_d;
   logic [15:0] k_q, k_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [31:0] asm_q, asm_d;
   logic [31:0] wr_word_q, wr_word_d;
   logic [31:0] wr_addr_q, wr_addr_d;
   logic        wr_pend_q, wr_pend_d;

   logic [15:0] n_full;
   logic [15:0] word_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_LEN_LO;
         n_q        <= '0;
         k_q        <= '0;
         byte_idx_q <= '0;
         asm_q      <= '0;
         wr_word_q  <= '0;
         wr_addr_q  <= '0;
         wr_pend_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         k_q        <= k_d;
         byte_idx_q <= byte_idx_d;
         asm_q      <= asm_d;
         wr_word_q  <= wr_word_d;
         wr_addr_q  <= wr_addr_d;
         wr_pend_q  <= wr_pend_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      k_d        = k_q;
      byte_idx_d = byte_idx_q;
      asm_d      = asm_q;
      wr_word_d  = wr_word_q;
      wr_addr_d  = wr_addr_q;
      wr_pend_d  = wr_pend_q;
      n_full     = {rx_data, n_q[7:0]};
      // words already captured, including one still waiting for its write cycle
      word_idx   = k_q + 16'(wr_pend_q);

      case (state_q)
         S_LEN_LO: begin
            if (rx_valid) begin
               n_d[7:0] = rx_data;
               state_d  = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (rx_valid) begin
               n_d[15:8] = rx_data;
               if (n_full == 16'd0 || {1'b0, n_full} > MAX_W) begin
                  state_d = S_ERR;
               end else begin
                  state_d    = S_DATA;
                  byte_idx_d = '0;
                  k_d        = '0;
               end
            end
         end
         S_DATA: begin
            if (wr_pend_q) begin
               wr_pend_d = 1'b0;
               k_d       = k_q + 16'd1;
               if (k_q == n_q - 16'd1) begin
                  state_d = S_RELEASE;
               end
            end
            // bytes past the last word of the frame are dropped
            if (rx_valid && word_idx < n_q) begin
               asm_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  wr_word_d = {rx_data, asm_q[23:0]};
                  wr_addr_d = BASE_ADDR + {14'd0, word_idx, 2'b00};
                  wr_pend_d = 1'b1;
               end
            end
         end
         S_RELEASE: state_d = S_RUN;
         S_RUN:     state_d = S_RUN;
         S_ERR:     state_d = S_ERR;
         default:   state_d = S_LEN_LO;
      endcase

      if (boot_req) begin
         state_d    = S_LEN_LO;
         byte_idx_d = '0;
         k_d        = '0;
         wr_pend_d  = 1'b0;
      end
   end

   always_comb begin
      cpu_rst_n = (state_q == S_RUN);
      busy      = (state_q != S_RUN);
      done      = (state_q == S_RUN);
      err       = (state_q == S_ERR);
      mem_addr  = '0;
      mem_wdata = '0;
      mem_rstrb = 1'b0;
      mem_wstrb = '0;
      if (state_q == S_RUN) begin
         mem_addr  = cpu_mem_addr;
         mem_wdata = cpu_mem_wdata;
         mem_rstrb = cpu_mem_rstrb;
         mem_wstrb = cpu_mem_wstrb;
      end else if (wr_pend_q) begin
         mem_addr  = wr_addr_q;
         mem_wdata = wr_word_q;
         mem_wstrb = 4'b1111;
      end
   end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// tb/tb_boot_loader_ctrl.sv - directed self-checking bench for boot_loader_ctrl
module tb_boot_loader_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        boot_req = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic [31:0] cpu_mem_addr = '0;
   logic [31:0] cpu_mem_wdata = '0;
   logic        cpu_mem_rstrb = 1'b0;
   logic [3:0]  cpu_mem_wstrb = '0;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rstrb;
   logic [3:0]  mem_wstrb;
   logic        cpu_rst_n;
   logic        busy;
   logic        done;
   logic        err;

   int errors = 0;
   int checks = 0;
   int writes = 0;

   boot_loader_ctrl dut (
      .clk(clk), .rst(rst), .boot_req(boot_req),
      .rx_valid(rx_valid), .rx_data(rx_data),
      .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
      .cpu_mem_rstrb(cpu_mem_rstrb), .cpu_mem_wstrb(cpu_mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rstrb(mem_rstrb), .mem_wstrb(mem_wstrb),
      .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // loader-owned RAM writes, one count per write cycle
   always @(negedge clk) begin
      if (busy && mem_wstrb != 4'b0000) writes++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic pulse_boot();
      boot_req = 1'b1;
      step();
      boot_req = 1'b0;
   endtask

   initial begin
      // asynchronous reset before any clock edge
      #2 rst = 1'b1;
      #1;
      chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
      step();
      step();
      rst = 1'b0;
      step();

      // normal load of two words
      send(8'h02); send(8'h00);
      send(8'h13); send(8'h00); send(8'h50); send(8'h00);
      chk("w0_wstrb", 32'(mem_wstrb), 32'hF);
      chk("w0_addr", mem_addr, 32'h0);
      chk("w0_data", mem_wdata, 32'h0050_0013);
      send(8'h73);
      chk("w0_one_cycle", 32'(mem_wstrb), 32'h0);
      send(8'h00); send(8'h10); send(8'h00);
      chk("w1_wstrb", 32'(mem_wstrb), 32'hF);
      chk("w1_addr", mem_addr, 32'h4);
      chk("w1_data", mem_wdata, 32'h0010_0073);
      chk("lat_edge1", 32'(cpu_rst_n), 32'd0);
      step();
      chk("lat_edge2", 32'(cpu_rst_n), 32'd0);
      chk("release_busy", 32'(busy), 32'd1);
      chk("release_wstrb", 32'(mem_wstrb), 32'h0);
      step();
      chk("lat_edge3", 32'(cpu_rst_n), 32'd1);
      chk("run_done", 32'(done), 32'd1);
      chk("run_busy", 32'(busy), 32'd0);
      chk("load_writes", 32'(writes), 32'd2);

      // run-mode pass-through mux
      cpu_mem_addr  = 32'h40;
      cpu_mem_wstrb = 4'b0011;
      cpu_mem_wdata = 32'hABCD;
      cpu_mem_rstrb = 1'b1;
      #1;
      chk("mux_addr", mem_addr, 32'h40);
      chk("mux_wstrb", 32'(mem_wstrb), 32'h3);
      chk("mux_wdata", mem_wdata, 32'hABCD);
      chk("mux_rstrb", 32'(mem_rstrb), 32'd1);
      cpu_mem_wstrb = 4'b0000;
      cpu_mem_rstrb = 1'b0;
      send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
      chk("run_rx_ignored_wstrb", 32'(mem_wstrb), 32'h0);
      chk("run_rx_ignored_done", 32'(done), 32'd1);
      chk("run_rx_writes", 32'(writes), 32'd2);

      // restart from RUN, then bad counts
      pulse_boot();
      chk("boot_done", 32'(done), 32'd0);
      chk("boot_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      chk("boot_mem_addr", mem_addr, 32'h0);
      send(8'h00); send(8'h00);
      chk("n0_err", 32'(err), 32'd1);
      chk("n0_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      chk("n0_err_sticky", 32'(err), 32'd1);
      chk("n0_writes", 32'(writes), 32'd2);
      pulse_boot();
      chk("boot_clears_err", 32'(err), 32'd0);
      send(8'h01); send(8'h02);
      chk("nbig_err", 32'(err), 32'd1);
      pulse_boot();
      chk("boot_clears_err2", 32'(err), 32'd0);

      // N = 256 is the largest legal count
      send(8'h00); send(8'h01);
      chk("nmax_no_err", 32'(err), 32'd0);
      pulse_boot();

      // back-to-back bytes with an extra byte in the write cycle
      send(8'h01); send(8'h00);
      send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
      chk("b2b_wstrb", 32'(mem_wstrb), 32'hF);
      chk("b2b_data", mem_wdata, 32'hDDCC_BBAA);
      send(8'hEE);
      chk("b2b_extra_wstrb", 32'(mem_wstrb), 32'h0);
      step();
      chk("b2b_run", 32'(cpu_rst_n), 32'd1);
      chk("b2b_writes", 32'(writes), 32'd3);

      // restart mid-load; boot_req and rx_valid together drop the byte
      pulse_boot();
      send(8'h02); send(8'h00);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      chk("mid_w0_data", mem_wdata, 32'h4433_2211);
      chk("mid_w0_addr", mem_addr, 32'h0);
      send(8'h55); send(8'h66);
      rx_valid = 1'b1;
      rx_data  = 8'h77;
      boot_req = 1'b1;
      step();
      boot_req = 1'b0;
      rx_valid = 1'b0;
      chk("mid_no_partial", 32'(mem_wstrb), 32'h0);
      chk("mid_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      chk("mid_writes", 32'(writes), 32'd4);
      send(8'h01); send(8'h00);
      send(8'h77); send(8'h88); send(8'h99); send(8'hAA);
      chk("fresh_addr", mem_addr, 32'h0);
      chk("fresh_data", mem_wdata, 32'hAA99_8877);
      step();
      step();
      chk("fresh_run", 32'(done), 32'd1);
      chk("fresh_writes", 32'(writes), 32'd5);

      // asynchronous reset while running
      cpu_mem_addr  = 32'h1234;
      cpu_mem_wdata = 32'h5678;
      cpu_mem_wstrb = 4'b1111;
      cpu_mem_rstrb = 1'b1;
      #1;
      chk("prerst_mux", mem_addr, 32'h1234);
      #1 rst = 1'b1;
      #1;
      chk("arst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_busy", 32'(busy), 32'd1);
      chk("arst_addr", mem_addr, 32'h0);
      chk("arst_wdata", mem_wdata, 32'h0);
      chk("arst_wstrb", 32'(mem_wstrb), 32'h0);
      chk("arst_rstrb", 32'(mem_rstrb), 32'd0);
      step();
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
